// File: rtl/count_monitor_if.sv
// Bus between the upstream counter/consumer side and count_monitor.
// Event handshake: a record transfers on a clk edge where evt_valid and evt_ready are both 1; evt_data holds steady while evt_valid is high and not yet taken.
interface count_monitor_if #(
    parameter int WRAP_W = 8,
    parameter int ERR_W  = 4
);
    logic [1:0]        val;
    logic              clear;
    logic              evt_ready;
    logic              evt_valid;
    logic [WRAP_W-1:0] evt_data;
    logic [WRAP_W-1:0] wrap_cnt;
    logic              err_step;
    logic [ERR_W-1:0]  err_cnt;
    logic              ovf;
    logic [1:0]        dbg_state;  // {event pending, tracker in TRACK}

    modport master (
        output val, clear, evt_ready,
        input  evt_valid, evt_data, wrap_cnt, err_step, err_cnt, ovf, dbg_state
    );

    modport slave (
        input  val, clear, evt_ready,
        output evt_valid, evt_data, wrap_cnt, err_step, err_cnt, ovf, dbg_state
    );
endinterface

// File: rtl/count_monitor.sv
// Checks a 2-bit counter for +1 mod 4 steps, counts 3->0 wraps and emits one
// handshaked event per THRESH wraps, with sticky error/overflow status.
module count_monitor #(
    parameter int WRAP_W = 8,
    parameter int THRESH = 4,
    parameter int ERR_W  = 4
) (
    input  logic           clk,
    input  logic           rst,
    count_monitor_if.slave bus
);
    typedef enum logic {INIT, TRACK}  trk_e;
    typedef enum logic {EMPTY, PEND}  evt_e;

    localparam logic [7:0]       GRP_LAST = 8'(THRESH - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    trk_e              trk_q, trk_d;
    evt_e              evt_st_q, evt_st_d;
    logic [1:0]        prev_q, prev_d;
    logic [WRAP_W-1:0] wrap_q, wrap_d;
    logic [7:0]        grp_q, grp_d;
    logic [WRAP_W-1:0] evt_data_q, evt_data_d;
    logic              err_step_q, err_step_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic              ovf_q, ovf_d;

    logic              step_err;
    logic              wrap;
    logic              new_evt;
    logic              drop;
    logic [1:0]        exp_val;
    logic [ERR_W-1:0]  err_base;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trk_q      <= INIT;
            evt_st_q   <= EMPTY;
            prev_q     <= '0;
            wrap_q     <= '0;
            grp_q      <= '0;
            evt_data_q <= '0;
            err_step_q <= 1'b0;
            err_cnt_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            trk_q      <= trk_d;
            evt_st_q   <= evt_st_d;
            prev_q     <= prev_d;
            wrap_q     <= wrap_d;
            grp_q      <= grp_d;
            evt_data_q <= evt_data_d;
            err_step_q <= err_step_d;
            err_cnt_q  <= err_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    // Tracker: the first sample after reset only seeds prev; afterwards every sample is checked.
    always_comb begin
        trk_d    = trk_q;
        step_err = 1'b0;
        wrap     = 1'b0;
        exp_val  = prev_q + 2'd1;
        prev_d   = bus.val;
        case (trk_q)
            INIT:  trk_d = TRACK;
            TRACK: begin
                step_err = (bus.val != exp_val);
                wrap     = (prev_q == 2'd3) && (bus.val == 2'd0) && !step_err;
            end
            default: trk_d = INIT;
        endcase
    end

    always_comb begin
        wrap_d  = wrap_q;
        grp_d   = grp_q;
        new_evt = 1'b0;
        if (wrap) begin
            wrap_d = wrap_q + WRAP_W'(1);
            if (grp_q == GRP_LAST) begin
                grp_d   = '0;
                new_evt = 1'b1;
            end else begin
                grp_d = grp_q + 8'd1;
            end
        end
    end

    // Event register: an accept and a new event in the same cycle reload without a bubble.
    always_comb begin
        evt_st_d   = evt_st_q;
        evt_data_d = evt_data_q;
        drop       = 1'b0;
        case (evt_st_q)
            EMPTY: begin
                if (new_evt) begin
                    evt_st_d   = PEND;
                    evt_data_d = wrap_d;
                end
            end
            PEND: begin
                if (bus.evt_ready) begin
                    if (new_evt) evt_data_d = wrap_d;
                    else         evt_st_d   = EMPTY;
                end else if (new_evt) begin
                    drop = 1'b1;
                end
            end
            default: evt_st_d = EMPTY;
        endcase
    end

    // Status: clear is applied first so a same-cycle set wins.
    always_comb begin
        err_base   = bus.clear ? '0 : err_cnt_q;
        err_step_d = (bus.clear ? 1'b0 : err_step_q) | step_err;
        err_cnt_d  = (step_err && err_base != ERR_MAX) ? err_base + ERR_W'(1) : err_base;
        ovf_d      = (bus.clear ? 1'b0 : ovf_q) | drop;
    end

    assign bus.evt_valid = (evt_st_q == PEND);
    assign bus.evt_data  = evt_data_q;
    assign bus.wrap_cnt  = wrap_q;
    assign bus.err_step  = err_step_q;
    assign bus.err_cnt   = err_cnt_q;
    assign bus.ovf       = ovf_q;
    assign bus.dbg_state = {evt_st_q == PEND, trk_q == TRACK};
endmodule

// File: tb/tb_count_monitor.sv
// Bench for count_monitor: table vectors, directed multi-cycle sequences and
// random stimulus, all checked against a wrap-count/event reference model.
module tb_count_monitor;
    localparam int WRAP_W = 8;
    localparam int THRESH = 4;
    localparam int ERR_W  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    count_monitor_if #(.WRAP_W(WRAP_W), .ERR_W(ERR_W)) bus ();

    count_monitor #(.WRAP_W(WRAP_W), .THRESH(THRESH), .ERR_W(ERR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_vec = 0;
    int n_bad = 0;
    logic [WRAP_W-1:0] exp_q[$];

    // Reference model state: total wraps since reset, unbounded error count.
    bit m_started, m_pend, m_err, m_ovf;
    int m_prev, m_wraps, m_data, m_errs;

    typedef struct {
        logic [1:0]        val;
        logic              clr;
        logic              rdy;
        logic [WRAP_W-1:0] wrap;
        logic              err;
        logic [ERR_W-1:0]  cnt;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started = 0; m_pend = 0; m_err = 0; m_ovf = 0;
        m_prev = 0; m_wraps = 0; m_data = 0; m_errs = 0;
    endtask

    task automatic model_update(input int v, input bit clr, input bit rdy);
        bit serr = 0, w = 0, newev = 0, acc, dropped = 0;
        if (m_started) begin
            serr = (v != (m_prev + 1) % 4);
            w    = (m_prev == 3 && v == 0);
        end
        m_started = 1;
        m_prev = v;
        if (w) begin
            m_wraps++;
            newev = (m_wraps % THRESH == 0);
        end
        acc = m_pend && rdy;
        if (newev) begin
            if (m_pend && !acc) dropped = 1;
            else begin
                m_pend = 1;
                m_data = m_wraps % (1 << WRAP_W);
            end
        end else if (acc) begin
            m_pend = 0;
        end
        if (clr) begin m_err = 0; m_ovf = 0; m_errs = 0; end
        if (serr) begin m_err = 1; m_errs++; end
        if (dropped) m_ovf = 1;
    endtask

    task automatic check_model();
        int sat = (m_errs > (1 << ERR_W) - 1) ? (1 << ERR_W) - 1 : m_errs;
        chk("evt_valid", 32'(bus.evt_valid), 32'(m_pend));
        chk("evt_data",  32'(bus.evt_data),  32'(m_data));
        chk("wrap_cnt",  32'(bus.wrap_cnt),  32'(m_wraps % (1 << WRAP_W)));
        chk("err_step",  32'(bus.err_step),  32'(m_err));
        chk("err_cnt",   32'(bus.err_cnt),   32'(sat));
        chk("ovf",       32'(bus.ovf),       32'(m_ovf));
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic [1:0] v, input logic clr, input logic rdy);
        bus.val = v; bus.clear = clr; bus.evt_ready = rdy;
        @(posedge clk);
        model_update(int'(v), clr, rdy);
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.val = 2'd0; bus.clear = 1'b0; bus.evt_ready = 1'b0;
        #1;
        model_reset();
        check_model();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int cur;
        bus.val = 2'd0; bus.clear = 1'b0; bus.evt_ready = 1'b0;
        tbl[0]  = '{2'd0, 1'b0, 1'b1, 8'd0, 1'b0, 4'd0};
        tbl[1]  = '{2'd1, 1'b0, 1'b1, 8'd0, 1'b0, 4'd0};
        tbl[2]  = '{2'd3, 1'b0, 1'b1, 8'd0, 1'b1, 4'd1};
        tbl[3]  = '{2'd0, 1'b0, 1'b1, 8'd1, 1'b1, 4'd1};
        tbl[4]  = '{2'd1, 1'b0, 1'b1, 8'd1, 1'b1, 4'd1};
        tbl[5]  = '{2'd2, 1'b0, 1'b1, 8'd1, 1'b1, 4'd1};
        tbl[6]  = '{2'd3, 1'b0, 1'b1, 8'd1, 1'b1, 4'd1};
        tbl[7]  = '{2'd0, 1'b0, 1'b1, 8'd2, 1'b1, 4'd1};
        tbl[8]  = '{2'd0, 1'b1, 1'b1, 8'd2, 1'b1, 4'd1};
        tbl[9]  = '{2'd1, 1'b1, 1'b1, 8'd2, 1'b0, 4'd0};
        tbl[10] = '{2'd2, 1'b0, 1'b1, 8'd2, 1'b0, 4'd0};
        tbl[11] = '{2'd1, 1'b0, 1'b1, 8'd2, 1'b1, 4'd1};
        @(negedge clk);

        // Table vectors
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].val, tbl[i].clr, tbl[i].rdy);
            chk("tbl_wrap", 32'(bus.wrap_cnt), 32'(tbl[i].wrap));
            chk("tbl_err",  32'(bus.err_step), 32'(tbl[i].err));
            chk("tbl_cnt",  32'(bus.err_cnt),  32'(tbl[i].cnt));
            chk("tbl_vld",  32'(bus.evt_valid), 32'd0);
        end

        // Ideal count, ready high: one-cycle pulses carrying 4, 8, 12
        do_reset();
        exp_q = '{8'd4, 8'd8, 8'd12};
        for (int i = 0; i < 52; i++) begin
            step(2'(i % 4), 1'b0, 1'b1);
            if (bus.evt_valid) begin
                if (exp_q.size() == 0) chk("evt_extra", 32'(bus.evt_data), 32'hFFFF_FFFF);
                else chk("evt_seq", 32'(bus.evt_data), 32'(exp_q.pop_front()));
            end
        end
        chk("evt_left", 32'(exp_q.size()), 32'd0);

        // Backpressure across two groups, then accept
        do_reset();
        for (int i = 0; i <= 32; i++) step(2'(i % 4), 1'b0, 1'b0);
        chk("bp_valid", 32'(bus.evt_valid), 32'd1);
        chk("bp_data",  32'(bus.evt_data),  32'd4);
        chk("bp_ovf",   32'(bus.ovf),       32'd1);
        step(2'd1, 1'b0, 1'b1);
        chk("bp_accept", 32'(bus.evt_valid), 32'd0);
        for (int i = 34; i <= 48; i++) step(2'(i % 4), 1'b0, 1'b1);
        chk("bp_next_valid", 32'(bus.evt_valid), 32'd1);
        chk("bp_next_data",  32'(bus.evt_data),  32'd12);

        // Clear against a same-cycle step error
        do_reset();
        step(2'd0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(2'd0, 1'b0, 1'b1);
        chk("clr_pre_cnt", 32'(bus.err_cnt), 32'd5);
        step(2'd0, 1'b1, 1'b1);
        chk("clr_set_cnt", 32'(bus.err_cnt),  32'd1);
        chk("clr_set_err", 32'(bus.err_step), 32'd1);
        step(2'd1, 1'b1, 1'b1);
        chk("clr_cnt", 32'(bus.err_cnt),  32'd0);
        chk("clr_err", 32'(bus.err_step), 32'd0);
        chk("clr_ovf", 32'(bus.ovf),      32'd0);

        // Error counter saturation
        do_reset();
        step(2'd0, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(2'd0, 1'b0, 1'b1);
        chk("sat_cnt", 32'(bus.err_cnt), 32'd15);

        // 256 wraps roll wrap_cnt over
        do_reset();
        for (int i = 0; i <= 1024; i++) begin
            step(2'(i % 4), 1'b0, 1'b1);
            if (i == 1020) chk("roll_255", 32'(bus.wrap_cnt), 32'd255);
        end
        chk("roll_0", 32'(bus.wrap_cnt), 32'd0);

        // Asynchronous reset while an event is pending, then reseed from 2
        do_reset();
        for (int i = 0; i <= 20; i++) step(2'(i % 4), 1'b0, 1'b0);
        chk("ar_pre_valid", 32'(bus.evt_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("ar_valid", 32'(bus.evt_valid), 32'd0);
        chk("ar_data",  32'(bus.evt_data),  32'd0);
        chk("ar_wrap",  32'(bus.wrap_cnt),  32'd0);
        chk("ar_err",   32'(bus.err_step),  32'd0);
        chk("ar_cnt",   32'(bus.err_cnt),   32'd0);
        chk("ar_ovf",   32'(bus.ovf),       32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(2'd2, 1'b0, 1'b1);
        chk("ar_seed_err", 32'(bus.err_step), 32'd0);
        step(2'd3, 1'b0, 1'b1);
        step(2'd0, 1'b0, 1'b1);
        chk("ar_resume_err",  32'(bus.err_step), 32'd0);
        chk("ar_resume_wrap", 32'(bus.wrap_cnt), 32'd1);

        // Random stimulus: mostly clean counting with occasional glitches
        do_reset();
        cur = $urandom_range(0, 3);
        step(2'(cur), 1'b0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) cur = $urandom_range(0, 3);
            else cur = (cur + 1) % 4;
            step(2'(cur), ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
